// File: rtl/d_cache_port_arbiter_pkg.sv
// Shared types and widths for the D-cache port arbiter and its store drain buffer.
package d_cache_port_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ROB_DEPTH_BITS = 4;
  localparam int unsigned SB_DEPTH_BITS  = 2;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } MemAccessType;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } store_buf_entry_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_LOAD,
    SEL_STORE
  } dc_arb_sel_t;

  // Contents of the registered D-cache request.
  typedef struct packed {
    logic                      valid;
    MemAccessType              action;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     data;
    logic [ROB_DEPTH_BITS-1:0] tag;
    logic                      squash;
  } dc_req_t;

endpackage

// File: rtl/d_cache_port_arbiter_if.sv
// Load-issue, store-commit, flush and D-cache request signals of the arbiter.
interface d_cache_port_arbiter_if
  import d_cache_port_arbiter_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

  logic                      ld_req_valid;
  logic [ADDR_WIDTH-1:0]     ld_req_addr;
  logic [ROB_DEPTH_BITS-1:0] ld_req_tag;
  logic                      ld_req_ready;
  logic                      st_commit_en;
  logic [ADDR_WIDTH-1:0]     st_commit_addr;
  logic [DATA_WIDTH-1:0]     st_commit_data;
  logic                      st_buf_full;
  logic [CNT_W-1:0]          st_buf_count;
  logic                      flush;
  logic                      dc_stall;
  logic                      dc_valid;
  MemAccessType              dc_mem_action;
  logic [ADDR_WIDTH-1:0]     dc_addr;
  logic [DATA_WIDTH-1:0]     dc_data;
  logic [ROB_DEPTH_BITS-1:0] dc_tag;
  logic                      dc_squash;

  modport slave (
    input  ld_req_valid, ld_req_addr, ld_req_tag,
    input  st_commit_en, st_commit_addr, st_commit_data,
    input  flush, dc_stall,
    output ld_req_ready, st_buf_full, st_buf_count,
    output dc_valid, dc_mem_action, dc_addr, dc_data, dc_tag, dc_squash
  );

  modport master (
    output ld_req_valid, ld_req_addr, ld_req_tag,
    output st_commit_en, st_commit_addr, st_commit_data,
    output flush, dc_stall,
    input  ld_req_ready, st_buf_full, st_buf_count,
    input  dc_valid, dc_mem_action, dc_addr, dc_data, dc_tag, dc_squash
  );

endinterface

// File: rtl/d_cache_port_arbiter_store_drain_fifo.sv
// Circular FIFO of committed stores awaiting the D-cache; exposes every live
// entry address so the arbiter can hold back aliasing loads.
module store_drain_fifo
  import d_cache_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push_i,
  input  store_buf_entry_t                    push_entry_i,
  input  logic                                pop_i,
  output store_buf_entry_t                    head_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic [$clog2(DEPTH):0]              count_o,
  output logic [DEPTH-1:0]                    ent_valid_o,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0]    ent_addr_o
);

  localparam int unsigned DB = $clog2(DEPTH);
  localparam int unsigned PW = DB + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  store_buf_entry_t mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;
  logic [DB-1:0]    offset;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DB] != rd_ptr_q[DB]) && (wr_ptr_q[DB-1:0] == rd_ptr_q[DB-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[DB-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
  end

  // Entry i is live when its distance from the read pointer is below the count.
  always_comb begin
    offset      = '0;
    ent_valid_o = '0;
    ent_addr_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = DB'(i) - rd_ptr_q[DB-1:0];
      ent_valid_o[i] = PW'(offset) < count_o;
      ent_addr_o[i]  = mem_q[i].addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DB-1:0]] <= push_entry_i;
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o))
    else $error("store_drain_fifo: store committed while buffer full, dropped");

endmodule

// File: rtl/d_cache_port_arbiter.sv
// Arbitrates the single D-cache port between speculative loads and buffered
// committed stores: load priority, store-starvation limit, store alias blocking.
module d_cache_port_arbiter
  import d_cache_port_arbiter_pkg::*;
#(
  parameter int unsigned SB_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  d_cache_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(SB_DEPTH) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  dc_req_t                              req_q, req_d;
  logic [STARVE_W-1:0]                  starve_q, starve_d;
  dc_arb_sel_t                          sel;
  store_buf_entry_t                     head;
  logic                                 fifo_empty, fifo_full, pop;
  logic [CNT_W-1:0]                     fifo_count;
  logic [SB_DEPTH-1:0]                  ent_valid;
  logic [SB_DEPTH-1:0][ADDR_WIDTH-1:0]  ent_addr;
  logic                                 alias_hit, ld_eligible, held_load, store_urgent;

  store_drain_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (bus.st_commit_en),
    .push_entry_i ('{addr: bus.st_commit_addr, data: bus.st_commit_data}),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_o      (fifo_count),
    .ent_valid_o  (ent_valid),
    .ent_addr_o   (ent_addr)
  );

  // A load must not overtake any older store to the same address.
  always_comb begin
    alias_hit = (req_q.valid && req_q.action == WRITE && req_q.addr == bus.ld_req_addr) ||
                (bus.st_commit_en && bus.st_commit_addr == bus.ld_req_addr);
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (ent_valid[i] && ent_addr[i] == bus.ld_req_addr) alias_hit = 1'b1;
    end
  end

  assign ld_eligible  = bus.ld_req_valid && !alias_hit && !bus.flush;
  assign held_load    = req_q.valid && req_q.action == READ;
  assign store_urgent = !fifo_empty && (starve_q == STARVE_W'(STARVE_LIMIT) || fifo_full);

  always_comb begin
    sel      = SEL_IDLE;
    req_d    = req_q;
    starve_d = starve_q;
    pop      = 1'b0;
    if (bus.dc_stall) begin
      if (bus.flush && held_load) req_d.squash = 1'b1;
    end else if (bus.flush && held_load) begin
      req_d = '0;
      if (fifo_empty) starve_d = '0;
    end else begin
      if (store_urgent)     sel = SEL_STORE;
      else if (ld_eligible) sel = SEL_LOAD;
      else if (!fifo_empty) sel = SEL_STORE;
      case (sel)
        SEL_STORE: begin
          req_d    = '{valid: 1'b1, action: WRITE, addr: head.addr, data: head.data,
                       tag: '0, squash: 1'b0};
          pop      = 1'b1;
          starve_d = '0;
        end
        SEL_LOAD: begin
          req_d = '{valid: 1'b1, action: READ, addr: bus.ld_req_addr, data: '0,
                    tag: bus.ld_req_tag, squash: 1'b0};
          if (fifo_empty)                              starve_d = '0;
          else if (starve_q != STARVE_W'(STARVE_LIMIT)) starve_d = starve_q + STARVE_W'(1);
        end
        default: begin
          req_d    = '0;
          starve_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= '0;
      starve_q <= '0;
    end else begin
      req_q    <= req_d;
      starve_q <= starve_d;
    end
  end

  assign bus.ld_req_ready  = (sel == SEL_LOAD);
  assign bus.st_buf_full   = fifo_full;
  assign bus.st_buf_count  = fifo_count;
  assign bus.dc_valid      = req_q.valid;
  assign bus.dc_mem_action = req_q.action;
  assign bus.dc_addr       = req_q.addr;
  assign bus.dc_data       = req_q.data;
  assign bus.dc_tag        = req_q.tag;
  assign bus.dc_squash     = req_q.squash;

endmodule

// File: tb/tb_d_cache_port_arbiter.sv
// Directed checks of the D-cache port arbiter: load/store latency, starvation,
// alias blocking, buffer full, flush handling and reset.
module tb_d_cache_port_arbiter;
  import d_cache_port_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  d_cache_port_arbiter_if #(.SB_DEPTH(4)) bus ();

  d_cache_port_arbiter #(.SB_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] a, input logic [31:0] d);
    bus.st_commit_en   = 1'b1;
    bus.st_commit_addr = a;
    bus.st_commit_data = d;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] t);
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = a;
    bus.ld_req_tag   = t;
  endtask

  task automatic check_req(input string tag, input logic v, input logic act,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    check({tag, ".valid"},  64'(bus.dc_valid), 64'(v));
    check({tag, ".action"}, 64'(bus.dc_mem_action), 64'(act));
    check({tag, ".addr"},   64'(bus.dc_addr), 64'(a));
    check({tag, ".data"},   64'(bus.dc_data), 64'(d));
    check({tag, ".tag"},    64'(bus.dc_tag), 64'(t));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.ld_req_valid = 1'b0; bus.ld_req_addr = '0; bus.ld_req_tag = '0;
    bus.st_commit_en = 1'b0; bus.st_commit_addr = '0; bus.st_commit_data = '0;
    bus.flush = 1'b0; bus.dc_stall = 1'b0;
    tick(); tick();

    check_req("rst", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("rst.squash", 64'(bus.dc_squash), 64'd0);
    check("rst.count",  64'(bus.st_buf_count), 64'd0);
    check("rst.full",   64'(bus.st_buf_full), 64'd0);
    check("rst.ready",  64'(bus.ld_req_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single load: granted same cycle, presented next cycle.
    load(32'h100, 4'd3);
    #1 check("ld.ready", 64'(bus.ld_req_ready), 64'd1);
    tick();
    bus.ld_req_valid = 1'b0;
    check_req("ld", 1'b1, 1'b0, 32'h100, 32'h0, 4'd3);
    tick();
    check("ld.idle", 64'(bus.dc_valid), 64'd0);

    // Single store drains one cycle after commit.
    commit(32'h200, 32'hDEAD);
    tick();
    bus.st_commit_en = 1'b0;
    check("st.count1", 64'(bus.st_buf_count), 64'd1);
    check("st.pre", 64'(bus.dc_valid), 64'd0);
    tick();
    check_req("st", 1'b1, 1'b1, 32'h200, 32'hDEAD, 4'h0);
    check("st.count0", 64'(bus.st_buf_count), 64'd0);
    tick();

    // Starvation: four load grants, then the buffered store, then loads again.
    bus.dc_stall = 1'b1;
    commit(32'h400, 32'h11);
    tick();
    bus.st_commit_en = 1'b0;
    check("starve.count", 64'(bus.st_buf_count), 64'd1);
    bus.dc_stall = 1'b0;
    load(32'h500, 4'd1);
    for (int i = 0; i < 7; i++) begin
      #1 check($sformatf("starve.ready%0d", i), 64'(bus.ld_req_ready), 64'(i != 4));
      tick();
      check($sformatf("starve.action%0d", i), 64'(bus.dc_mem_action), 64'(i == 4));
      if (i == 4) check("starve.st_addr", 64'(bus.dc_addr), 64'h400);
    end
    bus.ld_req_valid = 1'b0;
    tick();

    // Alias: load to a buffered store's address waits until the store has left.
    bus.dc_stall = 1'b1;
    commit(32'h300, 32'h33);
    tick();
    bus.st_commit_en = 1'b0;
    bus.dc_stall = 1'b0;
    load(32'h300, 4'd2);
    #1 check("alias.ready_a", 64'(bus.ld_req_ready), 64'd0);
    tick();
    check_req("alias.st", 1'b1, 1'b1, 32'h300, 32'h33, 4'h0);
    #1 check("alias.ready_b", 64'(bus.ld_req_ready), 64'd0);
    tick();
    check("alias.idle", 64'(bus.dc_valid), 64'd0);
    #1 check("alias.ready_c", 64'(bus.ld_req_ready), 64'd1);
    tick();
    bus.ld_req_valid = 1'b0;
    check_req("alias.ld", 1'b1, 1'b0, 32'h300, 32'h0, 4'd2);
    tick();

    // Full buffer forces a store ahead of a ready load.
    bus.dc_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      commit(32'h600 + 32'(i * 4), 32'(i));
      tick();
    end
    bus.st_commit_en = 1'b0;
    check("full.flag",  64'(bus.st_buf_full), 64'd1);
    check("full.count", 64'(bus.st_buf_count), 64'd4);
    bus.dc_stall = 1'b0;
    load(32'h700, 4'd5);
    #1 check("full.ready", 64'(bus.ld_req_ready), 64'd0);
    tick();
    check_req("full.st", 1'b1, 1'b1, 32'h600, 32'h0, 4'h0);
    check("full.count3", 64'(bus.st_buf_count), 64'd3);
    check("full.flag0",  64'(bus.st_buf_full), 64'd0);
    #1 check("full.ready2", 64'(bus.ld_req_ready), 64'd1);
    tick();
    bus.ld_req_valid = 1'b0;
    check_req("full.ld", 1'b1, 1'b0, 32'h700, 32'h0, 4'd5);
    for (int i = 0; i < 4; i++) tick();
    check("full.drained", 64'(bus.st_buf_count), 64'd0);
    check("full.idle", 64'(bus.dc_valid), 64'd0);

    // Flush while the held load is stalled: squash until it leaves.
    load(32'h800, 4'd7);
    tick();
    bus.ld_req_valid = 1'b0;
    bus.dc_stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_st.valid",  64'(bus.dc_valid), 64'd1);
    check("fl_st.squash", 64'(bus.dc_squash), 64'd1);
    check("fl_st.tag",    64'(bus.dc_tag), 64'd7);
    tick();
    check("fl_st.squash2", 64'(bus.dc_squash), 64'd1);
    bus.dc_stall = 1'b0;
    tick();
    check("fl_st.valid0",  64'(bus.dc_valid), 64'd0);
    check("fl_st.squash0", 64'(bus.dc_squash), 64'd0);

    // Flush without stall drops the held load but keeps a committed store.
    load(32'h900, 4'd4);
    tick();
    load(32'h904, 4'd6);
    bus.flush = 1'b1;
    commit(32'hA00, 32'hBEEF);
    #1 check("fl.ready", 64'(bus.ld_req_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.ld_req_valid = 1'b0;
    bus.st_commit_en = 1'b0;
    check("fl.valid0", 64'(bus.dc_valid), 64'd0);
    check("fl.count",  64'(bus.st_buf_count), 64'd1);
    tick();
    check_req("fl.st", 1'b1, 1'b1, 32'hA00, 32'hBEEF, 4'h0);
    tick();

    // Reset during a stall discards buffered stores.
    bus.dc_stall = 1'b1;
    commit(32'hB00, 32'h55);
    tick();
    bus.st_commit_en = 1'b0;
    check("rst2.pre", 64'(bus.st_buf_count), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2.count", 64'(bus.st_buf_count), 64'd0);
    check("rst2.valid", 64'(bus.dc_valid), 64'd0);
    bus.dc_stall = 1'b0;
    tick();
    check("rst2.idle", 64'(bus.dc_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/d_cache_port_arbiter.md
# d_cache_port_arbiter

Shares the single D-cache request port between two requesters:
- speculative loads issued by the memory reservation station;
- committed stores retired by the ROB.

Committed stores are buffered in a small drain FIFO. The arbiter picks one request per cycle with load priority and a store-starvation limit. It blocks loads that alias a pending store and presents a registered request to the D-cache, held while the cache stalls.

## Interface
Parameters:
- SB_DEPTH, 4: store drain buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive load grants allowed while a store waits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- ld_req_valid  in  1  reservation-station head load ready to issue.
- ld_req_addr  in  ADDR_WIDTH  load address.
- ld_req_tag  in  ROB_DEPTH_BITS  load ROB tag.
- ld_req_ready  out  1  load granted this cycle (combinational); station pops its head on valid&ready.
- st_commit_en  in  1  ROB retiring a store.
- st_commit_addr  in  ADDR_WIDTH  store address.
- st_commit_data  in  DATA_WIDTH  store data.
- st_buf_full  out  1  buffer full; ROB must not retire a store.
- st_buf_count  out  $clog2(SB_DEPTH)+1  occupied entries.
- flush  in  1  branch-mispredict flush.
- dc_stall  in  1  D-cache busy; hold request.
- dc_valid  out  1  request valid.
- dc_mem_action  out  MemAccessType  READ/WRITE.
- dc_addr  out  ADDR_WIDTH  request address.
- dc_data  out  DATA_WIDTH  write data; 0 for loads.
- dc_tag  out  ROB_DEPTH_BITS  load tag; 0 for stores.
- dc_squash  out  1  held load belongs to a flushed path; the CDB must drop its result.

## Operation
Store buffer:
- Circular FIFO with a (DEPTH_BITS+1)-bit write pointer and read pointer; the MSBs disambiguate full from empty.
- Push when st_commit_en=1 and not full.
- Push while full is a protocol violation: the push is dropped and a simulation assertion fires.

Load alias check: a load is eligible only if ld_req_valid=1 and ld_req_addr matches none of the following (full-width compare):
- any valid buffer entry;
- a store held in the output register;
- st_commit_addr when st_commit_en=1 in the same cycle.

Output register update, when dc_stall=0 and flush=0, priority order:
1. Buffer non-empty and (starve_cnt==STARVE_LIMIT or st_buf_full) → issue store.
2. Eligible load → issue load; ld_req_ready=1.
3. Buffer non-empty → issue store.
4. Otherwise dc_valid←0 and all fields←0.

Issuing a store pops the buffer head.

starve_cnt:
- Increments (saturating at STARVE_LIMIT) on each load grant while the buffer is non-empty.
- Clears on a store issue or when the buffer is empty.

Stall:
- When dc_stall=1, the output register, starve_cnt and buffer read pointer hold, and ld_req_ready=0.
- Pushes still occur during stall.

Flush (committed stores are never discarded):
- ld_req_ready=0 during flush.
- Held load with dc_stall=0: dc_valid←0.
- Held load with dc_stall=1: the load stays and dc_squash←1 until the request leaves the register.
- A held store is unaffected by flush.
- When flush=1 and dc_stall=0 with no held load, the normal store path (rules 1 and 3) applies; loads are ineligible.

## Timing
- Reset: dc_valid=0, dc_mem_action=READ, dc_addr/dc_data/dc_tag=0, dc_squash=0, st_buf_count=0, st_buf_full=0, ld_req_ready=0, starve_cnt=0, pointers=0.
- Load latency: grant at cycle t (ld_req_ready=1) → dc_valid=1 with the load at t+1.
- Store latency: commit at edge t → earliest dc_valid store at edge t+1.
- Simultaneous push and pop: count unchanged.
- The buffer full flag is computed from registered pointers, with no same-cycle pop credit.
- Pointer wrap-around is via natural overflow of the (DEPTH_BITS+1)-bit counters.
- Reset asserted mid-stall clears everything, including buffered stores.

## Structure
- Add to mips_core_pkg:
  - SB_DEPTH_BITS;
  - store_buf_entry_t {addr, data};
  - dc_arb_sel_t enum {SEL_IDLE, SEL_LOAD, SEL_STORE}.
- Sub-module store_drain_fifo:
  - holds storage, pointers, count and full;
  - exposes a per-entry valid/addr vector for the alias compare.
- The arbiter holds the select logic, starve_cnt and the output register.

## Test plan
- Idle, then ld_req_valid with addr 0x100, tag 3 → ld_req_ready same cycle; next cycle dc_valid=1, READ, dc_addr=0x100, dc_tag=3.
- Commit store 0x200/0xDEAD with no loads pending → next cycle WRITE 0x200, data 0xDEAD; count returns to 0.
- Buffer one store; present continuous unaliased loads → exactly 4 load grants, then the store issues, then loads resume.
- Buffered store to 0x300; load to 0x300 → ld_req_ready=0 until the store issues; the load is granted in the cycle after.
- Four commits with no drain → st_buf_full=1 and count=4; a fifth commit is dropped (assertion); the next issue is a store regardless of load.
- Load held with dc_stall=1 and flush pulse → dc_squash=1 while held; it clears when stall drops. Repeat with dc_stall=0 → dc_valid=0 next cycle and stores are retained.
